// File: rtl/neuron_weight_seq.sv
// Weight sequencer: streams NUM_WEIGHTS weights from a 1-cycle-latency ROM to a MAC via a 2-entry skid buffer.
// Optional abort input is present only when NEURON_WEIGHT_SEQ_ABORT_EN is defined.
module neuron_weight_seq #(
    parameter int NUM_WEIGHTS = 785,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
`ifdef NEURON_WEIGHT_SEQ_ABORT_EN
    input  logic              abort,
`endif
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_dout,
    input  logic              rom_valid,
    output logic [31:0]       w_data,
    output logic [ADDR_W-1:0] w_index,
    output logic              w_valid,
    input  logic              w_ready,
    output logic              w_last,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [31:0]       data;
        logic [ADDR_W-1:0] idx;
    } entry_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WEIGHTS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              infl_q, infl_d;
    logic [ADDR_W-1:0] infl_idx_q, infl_idx_d;
    logic [1:0]        cnt_q, cnt_d;
    entry_t            skid_q [2];
    entry_t            skid_d [2];
    logic              err_q, err_d;
    logic              abort_w;
    logic              pop;
    logic              cap_ok;
    logic              cap_fail;
    logic              issue;

`ifdef NEURON_WEIGHT_SEQ_ABORT_EN
    assign abort_w = abort && (state_q != IDLE);
`else
    assign abort_w = 1'b0;
`endif

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        pop      = (cnt_q != 2'd0) && w_ready;
        cap_ok   = infl_q && rom_valid && !abort_w;
        cap_fail = infl_q && !rom_valid && !abort_w;
        // A failed capture suppresses this cycle's issue so the missing index is re-read before its successor.
        issue    = (state_q == FETCH) && !abort_w && !cap_fail &&
                   (((cnt_q + 2'(infl_q)) < 2'd2) || pop);

        state_d    = state_q;
        addr_d     = addr_q;
        err_d      = err_q;
        infl_d     = issue;
        infl_idx_d = issue ? addr_q : infl_idx_q;

        // NOTE: blocking assignments here, since later statements read the partially updated skid_d/cnt_d.
        skid_d = skid_q;
        cnt_d  = cnt_q;
        if (pop) begin
            skid_d[0] = skid_q[1];
            cnt_d     = cnt_q - 2'd1;
        end
        if (cap_ok) begin
            if (cnt_d == 2'd0) skid_d[0] = '{data: rom_dout, idx: infl_idx_q};
            else               skid_d[1] = '{data: rom_dout, idx: infl_idx_q};
            cnt_d = cnt_d + 2'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    addr_d  = '0;
                    err_d   = 1'b0;
                end
            end
            FETCH: begin
                if (issue) begin
                    if (addr_q == LAST_IDX) state_d = DRAIN;
                    else                    addr_d  = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (pop && w_last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (cap_fail) begin
            err_d   = 1'b1;
            addr_d  = infl_idx_q;
            state_d = FETCH;
        end

        if (abort_w) begin
            state_d = IDLE;
            infl_d  = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            infl_q     <= 1'b0;
            infl_idx_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            infl_q     <= infl_d;
            infl_idx_q <= infl_idx_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // NOTE: payload storage is not reset; cnt_q gates every output, so stale entries are never visible.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    assign rom_addr = (state_q == FETCH) ? addr_q : '0;
    assign w_valid  = (cnt_q != 2'd0);
    assign w_data   = w_valid ? skid_q[0].data : '0;
    assign w_index  = w_valid ? skid_q[0].idx  : '0;
    assign w_last   = w_valid && (skid_q[0].idx == LAST_IDX);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE) && !abort_w;
    assign err      = err_q;

endmodule
